bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Two-master arbiter for the shared 8-bit register bus (addr / write data / write enable / read data) that feeds the pps_div blocks, main_memory and mux_data_read.
- Master 0 is the SPI slave block. Master 1 is a secondary master, e.g. the thunderbolt UART command decoder.
- Sequences each access with a fixed read-settle wait to cover the registered read-data path, then returns read data and an ack to the winning master.
- Uses round-robin fairness on simultaneous requests.

Parameters:
- ADDR_W, 8, width of address bus and master address inputs.
- DATA_W, 8, width of write and read data.
- HOLD_CYCLES, 2, cycles the address is held after ACCESS before read data is captured. Legal range 1..15; the bench rejects 0.

Ports:
- i_clk  in  1  system clock (10 MHz domain).
- i_rst  in  1  reset.
- i_req0, i_req1  in  1  transaction request, level.
- i_addr0, i_addr1  in  ADDR_W  transaction address.
- i_data0, i_data1  in  DATA_W  write data.
- i_wr0, i_wr1  in  1  1 = write, 0 = read.
- o_gnt0, o_gnt1  out  1  master owns bus (ACCESS through DONE).
- o_ack0, o_ack1  out  1  one-cycle completion pulse.
- o_rdata0, o_rdata1  out  DATA_W  last read result for that master.
- o_addr_bus  out  ADDR_W  shared bus address.
- o_data_write_bus  out  DATA_W  shared bus write data.
- o_wr_enable_bus  out  1  shared bus write strobe.
- i_data_read_bus  in  DATA_W  shared bus read data.

Interface rule (already decided): one clock; reset is asynchronous and active-high.

Behaviour:
- Reset: all outputs 0, state IDLE, wait counter 0, round-robin pointer favours master 0.
- Reset asserted mid-transaction: aborts immediately. No ack; o_wr_enable_bus drops asynchronously.

States:
- IDLE:
  - Samples i_req0/i_req1 at the edge ending the cycle.
  - If neither is high, stay in IDLE.
  - If exactly one is high, grant it.
  - If both are high, grant the master the pointer favours.
  - On grant, latch addr/data/wr of the winner and go to ACCESS.
- ACCESS (1 cycle):
  - o_gntN=1; o_addr_bus and o_data_write_bus driven from the latch.
  - o_wr_enable_bus = latched wr, this cycle only.
  - Go to WAIT with counter = HOLD_CYCLES-1.
- WAIT (HOLD_CYCLES cycles):
  - Address/data held; o_wr_enable_bus=0.
  - Decrement counter; at 0, go to DONE.
  - For reads, i_data_read_bus is captured into o_rdataN at the edge ending the last WAIT cycle.
- DONE (1 cycle):
  - o_ackN=1 and o_gntN=1.
  - Pointer set to favour the other master.
  - Go to IDLE.

Latency and throughput:
- Request sampled at edge E: ACCESS in cycle E+1, ack in cycle E+2+HOLD_CYCLES (E+4 at default).
- Writes use the same latency as reads.
- Back-to-back transactions: one IDLE cycle between DONE and the next ACCESS, so minimum period is HOLD_CYCLES+3 cycles.

Handshake rules:
- The master holds req until it sees ack, and drops req at the edge ending the ack cycle.
- The payload is latched at grant, so changes to addr/data/wr after the grant edge are ignored.
- A request withdrawn before grant is never serviced.
- A request withdrawn after grant still completes and acks.

Bus signals between transactions:
- o_addr_bus and o_data_write_bus hold their last values; o_wr_enable_bus=0.
- Grants are mutually exclusive; o_gnt0 & o_gnt1 is never 1.

Read data:
- o_rdataN changes only on a read completion for master N; writes leave it unchanged.

Arithmetic and width:
- No address decode; the address is passed through unchanged.
- Wait counter is 4 bits.

Test Plan:
1. Reset, then req0 write addr=0x10 data=0xA5 -> exactly one cycle of o_wr_enable_bus=1 with o_addr_bus=0x10 and o_data_write_bus=0xA5 in ACCESS; o_ack0 4 cycles after sampling edge; o_gnt1 stays 0.
2. req1 read addr=0x22 with bus model returning 0x3C two cycles after address -> o_rdata1=0x3C in the ack cycle; o_wr_enable_bus never 1; o_rdata0 unchanged.
3. req0 and req1 asserted in the same cycle, both held for repeated transactions -> grants alternate 0,1,0,1; 5-cycle spacing between ACCESS cycles.
4. Only req0 held for 3 transactions -> consecutive grants to 0 with one IDLE cycle between DONE and ACCESS.
5. Change i_addr0 to 0x55 after grant with latched value 0x10 -> bus still shows 0x10 through DONE.
6. Assert i_rst during WAIT of a write -> all outputs 0 immediately; no ack; after release, the first simultaneous request is granted to master 0.

Source files
------------

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master round-robin arbiter for the shared 8-bit register bus.
// Each access runs IDLE -> ACCESS (1) -> WAIT (HOLD_CYCLES) -> DONE (1) -> IDLE.
// The WAIT phase covers the registered read-data path of the bus slaves.
//
// Ports:
//   i_clk, i_rst                 clock, asynchronous active-high reset
//   i_reqN                       level request from master N (0 = SPI slave, 1 = secondary)
//   i_addrN, i_dataN, i_wrN      payload of master N (latched at grant)
//   o_gntN                       master N owns the bus, ACCESS through DONE
//   o_ackN                       one-cycle completion pulse in DONE
//   o_rdataN                     last read result for master N
//   o_addr_bus                   shared bus address (holds between accesses)
//   o_data_write_bus             shared bus write data (holds between accesses)
//   o_wr_enable_bus              shared bus write strobe, ACCESS cycle only
//   i_data_read_bus              shared bus read data
module bus_arbiter #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req0,
    input  logic              i_req1,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [DATA_W-1:0] i_data0,
    input  logic [DATA_W-1:0] i_data1,
    input  logic              i_wr0,
    input  logic              i_wr1,
    output logic              o_gnt0,
    output logic              o_gnt1,
    output logic              o_ack0,
    output logic              o_ack1,
    output logic [DATA_W-1:0] o_rdata0,
    output logic [DATA_W-1:0] o_rdata1,
    output logic [ADDR_W-1:0] o_addr_bus,
    output logic [DATA_W-1:0] o_data_write_bus,
    output logic              o_wr_enable_bus,
    input  logic [DATA_W-1:0] i_data_read_bus
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             owner_q;    // 1 = master 1 holds the bus
    logic             wr_q;       // latched write flag of the current access
    logic             favour1_q;  // round-robin pointer: 1 = master 1 wins a tie
    logic             pick1;

    // Winner if sampled this cycle: master 1 when alone, or on a tie it is favoured.
    assign pick1 = i_req1 && (!i_req0 || favour1_q);

    // Arbiter FSM; the shared bus address/data registers double as the payload latch.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state            <= S_IDLE;
            cnt              <= '0;
            owner_q          <= 1'b0;
            wr_q             <= 1'b0;
            favour1_q        <= 1'b0;
            o_gnt0           <= 1'b0;
            o_gnt1           <= 1'b0;
            o_ack0           <= 1'b0;
            o_ack1           <= 1'b0;
            o_rdata0         <= '0;
            o_rdata1         <= '0;
            o_addr_bus       <= '0;
            o_data_write_bus <= '0;
            o_wr_enable_bus  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_req0 || i_req1) begin
                        owner_q          <= pick1;
                        o_gnt0           <= !pick1;
                        o_gnt1           <= pick1;
                        o_addr_bus       <= pick1 ? i_addr1 : i_addr0;
                        o_data_write_bus <= pick1 ? i_data1 : i_data0;
                        wr_q             <= pick1 ? i_wr1 : i_wr0;
                        o_wr_enable_bus  <= pick1 ? i_wr1 : i_wr0;
                        state            <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    o_wr_enable_bus <= 1'b0;
                    cnt             <= CNT_W'(HOLD_CYCLES - 1);
                    state           <= S_WAIT;
                end
                S_WAIT: begin
                    if (cnt == '0) begin
                        // Read data has settled by the last WAIT cycle.
                        if (!wr_q) begin
                            if (owner_q) o_rdata1 <= i_data_read_bus;
                            else         o_rdata0 <= i_data_read_bus;
                        end
                        o_ack0 <= !owner_q;
                        o_ack1 <= owner_q;
                        state  <= S_DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    o_ack0    <= 1'b0;
                    o_ack1    <= 1'b0;
                    o_gnt0    <= 1'b0;
                    o_gnt1    <= 1'b0;
                    favour1_q <= !owner_q;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: self-checking bench for bus_arbiter.
// A transaction-level reference model (schedule of accesses, round-robin favour,
// reference memory) predicts every DUT output each cycle; directed table vectors
// and hand-written sequences cover latency, fairness, latching and reset abort,
// followed by a randomized two-master phase.
module tb_bus_arbiter;

    localparam int unsigned AW   = 8;
    localparam int unsigned DW   = 8;
    localparam int unsigned HOLD = 2;
    localparam int LAT    = HOLD + 2;   // from the cycle the request is first sampled to ack
    localparam int PERIOD = HOLD + 3;   // ACCESS-to-ACCESS spacing when back-to-back

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req0 = 1'b0, req1 = 1'b0, wr0 = 1'b0, wr1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] data0 = '0, data1 = '0;
    logic [DW-1:0] rd_bus;
    logic gnt0, gnt1, ack0, ack1, we;
    logic [DW-1:0] rdata0, rdata1, dbus;
    logic [AW-1:0] abus;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] slave_mem [256];
    logic [7:0] ref_mem   [256];

    int w_own [8];
    int w_at  [8];

    bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .HOLD_CYCLES(HOLD)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req0(req0), .i_req1(req1),
        .i_addr0(addr0), .i_addr1(addr1),
        .i_data0(data0), .i_data1(data1),
        .i_wr0(wr0), .i_wr1(wr1),
        .o_gnt0(gnt0), .o_gnt1(gnt1),
        .o_ack0(ack0), .o_ack1(ack1),
        .o_rdata0(rdata0), .o_rdata1(rdata1),
        .o_addr_bus(abus), .o_data_write_bus(dbus),
        .o_wr_enable_bus(we), .i_data_read_bus(rd_bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Bus slave: registered read, write on the strobe.
    always @(posedge clk) begin
        if (we) slave_mem[abus] <= dbus;
        rd_bus <= slave_mem[abus];
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: bench did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Transaction-level reference model, evaluated mid-cycle.
    bit         m_act = 1'b0, m_own = 1'b0, m_wr = 1'b0, m_fav = 1'b0;
    logic [7:0] m_addr = '0, m_data = '0;
    logic [7:0] e_addr = '0, e_data = '0, e_rd0 = '0, e_rd1 = '0;
    int         m_s = 0, m_next = 0;

    always @(negedge clk) begin : model
        int ph;
        bit eg0, eg1, ea0, ea1, ewe;
        ph = cyc - m_s;
        if (rst) begin
            m_act = 1'b0; m_fav = 1'b0; m_next = 0;
            e_addr = '0; e_data = '0; e_rd0 = '0; e_rd1 = '0;
            eg0 = 1'b0; eg1 = 1'b0; ea0 = 1'b0; ea1 = 1'b0; ewe = 1'b0;
        end else begin
            eg0 = m_act && !m_own;
            eg1 = m_act && m_own;
            ewe = m_act && m_wr && ph == 0;
            ea0 = eg0 && ph == int'(HOLD) + 1;
            ea1 = eg1 && ph == int'(HOLD) + 1;
            if (m_act) begin
                e_addr = m_addr;
                e_data = m_data;
            end
            if (m_act && ph == int'(HOLD) + 1 && !m_wr) begin
                if (m_own) e_rd1 = ref_mem[m_addr];
                else       e_rd0 = ref_mem[m_addr];
            end
        end
        chk("m_gnt0", 32'(gnt0), 32'(eg0));
        chk("m_gnt1", 32'(gnt1), 32'(eg1));
        chk("m_ack0", 32'(ack0), 32'(ea0));
        chk("m_ack1", 32'(ack1), 32'(ea1));
        chk("m_wr_enable", 32'(we), 32'(ewe));
        chk("m_addr_bus", 32'(abus), 32'(e_addr));
        chk("m_data_bus", 32'(dbus), 32'(e_data));
        chk("m_rdata0", 32'(rdata0), 32'(e_rd0));
        chk("m_rdata1", 32'(rdata1), 32'(e_rd1));
        if (!rst) begin
            if (m_act && ph == int'(HOLD) + 1) begin
                m_act  = 1'b0;
                m_next = cyc + 1;
            end else if (!m_act && cyc >= m_next && (req0 || req1)) begin
                m_own  = (req0 && req1) ? m_fav : req1;
                m_addr = m_own ? addr1 : addr0;
                m_data = m_own ? data1 : data0;
                m_wr   = m_own ? wr1 : wr0;
                if (m_wr) ref_mem[m_addr] = m_data;
                m_fav  = !m_own;
                m_s    = cyc + 1;
                m_act  = 1'b1;
            end
        end
    end

    task automatic set_req(input bit m, input bit r, input bit wr, input logic [7:0] a, input logic [7:0] d);
        if (m) begin req1 = r; wr1 = wr; addr1 = a; data1 = d; end
        else   begin req0 = r; wr0 = wr; addr0 = a; data0 = d; end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Single request; returns cycles from first sampled request to ack, and read data.
    task automatic run_txn(input bit m, input bit wr, input logic [7:0] a, input logic [7:0] d,
                           output int lat, output logic [7:0] rd);
        lat = -1;
        rd  = '0;
        set_req(m, 1'b1, wr, a, d);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if ((m ? ack1 : ack0) == 1'b1) begin
                lat = k;
                rd  = m ? rdata1 : rdata0;
                break;
            end
        end
        @(posedge clk); #1;
        set_req(m, 1'b0, wr, a, d);
    endtask

    // Records owner and cycle offset of each new grant.
    task automatic watch(input int n, output int got);
        bit p0 = 1'b0, p1 = 1'b0;
        got = 0;
        for (int k = 0; k < 80 && got < n; k++) begin
            @(negedge clk);
            if ((gnt0 && !p0) || (gnt1 && !p1)) begin
                w_own[got] = int'(gnt1);
                w_at[got]  = k;
                got++;
            end
            p0 = gnt0;
            p1 = gnt1;
        end
    endtask

    typedef struct {
        bit         m;
        bit         wr;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] exp_rd;
        int         exp_lat;
    } vec_t;

    function automatic vec_t mk(input bit m, input bit wr, input logic [7:0] a,
                                input logic [7:0] d, input logic [7:0] e);
        vec_t v;
        v.m = m; v.wr = wr; v.addr = a; v.data = d; v.exp_rd = e; v.exp_lat = LAT;
        return v;
    endfunction

    initial begin : main
        vec_t tbl [8];
        int lat, got;
        logic [7:0] rd;
        bit sa0, sa1, sg0, sg1;

        if (HOLD < 1 || HOLD > 15) begin
            $display("FAIL hold_cycles_param out of range: %0d", HOLD);
            $fatal(1);
        end

        for (int i = 0; i < 256; i++) begin
            slave_mem[i] = ~8'(i);
            ref_mem[i]   = ~8'(i);
        end
        slave_mem[8'h22] = 8'h3C;
        ref_mem[8'h22]   = 8'h3C;

        tbl[0] = mk(1'b0, 1'b1, 8'h10, 8'hA5, 8'h00);  // write leaves rdata0 at reset value
        tbl[1] = mk(1'b1, 1'b0, 8'h22, 8'h00, 8'h3C);
        tbl[2] = mk(1'b0, 1'b0, 8'h10, 8'h00, 8'hA5);
        tbl[3] = mk(1'b1, 1'b1, 8'h10, 8'h5A, 8'h3C);
        tbl[4] = mk(1'b0, 1'b0, 8'h10, 8'h00, 8'h5A);
        tbl[5] = mk(1'b1, 1'b0, 8'h80, 8'h00, 8'h7F);
        tbl[6] = mk(1'b0, 1'b1, 8'h00, 8'hFF, 8'h5A);
        tbl[7] = mk(1'b1, 1'b0, 8'h00, 8'h00, 8'hFF);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gnt0", 32'(gnt0), 32'd0);
        chk("rst_gnt1", 32'(gnt1), 32'd0);
        chk("rst_wr_enable", 32'(we), 32'd0);
        chk("rst_addr_bus", 32'(abus), 32'd0);
        chk("rst_rdata0", 32'(rdata0), 32'd0);
        rst = 1'b0;
        idle(1);

        // Single-master vectors
        for (int i = 0; i < 8; i++) begin
            run_txn(tbl[i].m, tbl[i].wr, tbl[i].addr, tbl[i].data, lat, rd);
            chk("tbl_latency", 32'(lat), 32'(tbl[i].exp_lat));
            chk("tbl_rdata", 32'(rd), 32'(tbl[i].exp_rd));
        end
        idle(2);

        // Simultaneous held requests alternate; last completion was master 1.
        set_req(1'b0, 1'b1, 1'b0, 8'h30, 8'h00);
        set_req(1'b1, 1'b1, 1'b0, 8'h31, 8'h00);
        watch(4, got);
        chk("rr_count", 32'(got), 32'd4);
        for (int i = 0; i < 4; i++) chk("rr_owner", 32'(w_own[i]), 32'(i % 2));
        for (int i = 0; i < 3; i++) chk("rr_spacing", 32'(w_at[i+1] - w_at[i]), 32'(PERIOD));
        @(posedge clk); #1;
        req0 = 1'b0; req1 = 1'b0;
        idle(10);

        // Single held requester is granted back-to-back.
        set_req(1'b0, 1'b1, 1'b1, 8'h40, 8'h11);
        watch(3, got);
        chk("solo_count", 32'(got), 32'd3);
        for (int i = 0; i < 3; i++) chk("solo_owner", 32'(w_own[i]), 32'd0);
        for (int i = 0; i < 2; i++) chk("solo_spacing", 32'(w_at[i+1] - w_at[i]), 32'(PERIOD));
        @(posedge clk); #1;
        req0 = 1'b0;
        idle(10);

        // Payload change and withdrawal after grant; master 1 withdraws before grant.
        set_req(1'b0, 1'b1, 1'b0, 8'h10, 8'h00);
        for (int k = 0; k < 10 && !gnt0; k++) @(negedge clk);
        chk("latch_grant", 32'(gnt0), 32'd1);
        @(posedge clk); #1;
        addr0 = 8'h55; req0 = 1'b0;
        set_req(1'b1, 1'b1, 1'b0, 8'h66, 8'h00);
        @(negedge clk);
        chk("latch_addr_wait1", 32'(abus), 32'h10);
        @(posedge clk); #1;
        req1 = 1'b0;
        @(negedge clk);
        chk("latch_addr_wait2", 32'(abus), 32'h10);
        @(negedge clk);
        chk("latch_addr_done", 32'(abus), 32'h10);
        chk("latch_ack_after_withdraw", 32'(ack0), 32'd1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("withdrawn_not_granted", 32'(gnt1), 32'd0);
        end
        @(posedge clk); #1;

        // Reset during WAIT of a write aborts; pointer returns to master 0.
        set_req(1'b0, 1'b1, 1'b1, 8'h44, 8'h99);
        for (int k = 0; k < 10 && !gnt0; k++) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("abort_gnt0", 32'(gnt0), 32'd0);
        chk("abort_wr_enable", 32'(we), 32'd0);
        chk("abort_addr_bus", 32'(abus), 32'd0);
        chk("abort_data_bus", 32'(dbus), 32'd0);
        chk("abort_rdata0", 32'(rdata0), 32'd0);
        req0 = 1'b0;
        idle(2);
        rst = 1'b0;
        set_req(1'b0, 1'b1, 1'b0, 8'h60, 8'h00);
        set_req(1'b1, 1'b1, 1'b0, 8'h61, 8'h00);
        for (int k = 0; k < 10 && !(gnt0 || gnt1); k++) @(negedge clk);
        chk("post_reset_gnt0", 32'(gnt0), 32'd1);
        chk("post_reset_gnt1", 32'(gnt1), 32'd0);
        @(posedge clk); #1;
        req0 = 1'b0; req1 = 1'b0;
        idle(10);

        // Randomized two-master traffic; masters drop req right after their ack.
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            sa0 = ack0; sa1 = ack1; sg0 = gnt0; sg1 = gnt1;
            @(posedge clk); #1;
            if (req0 && sa0) req0 = 1'b0;
            else if (!req0 && $urandom_range(0, 2) == 0)
                set_req(1'b0, 1'b1, 1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom));
            else if (req0 && sg0)
                set_req(1'b0, 1'b1, 1'($urandom), 8'($urandom), 8'($urandom));
            if (req1 && sa1) req1 = 1'b0;
            else if (!req1 && $urandom_range(0, 2) == 0)
                set_req(1'b1, 1'b1, 1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom));
            else if (req1 && sg1)
                set_req(1'b1, 1'b1, 1'($urandom), 8'($urandom), 8'($urandom));
        end
        req0 = 1'b0; req1 = 1'b0;
        idle(12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
